// File: rtl/stack_pkg.sv
// Shared encodings and defaults for the stack operation sequencer.
package stack_pkg;

    localparam logic [31:0] DEF_STACK_BASE  = 32'd900;
    localparam logic [31:0] DEF_STACK_LIMIT = 32'd772;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_INT  = 3'd5,
        OP_RTI  = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        KIND_DATA  = 2'd0,
        KIND_PC    = 2'd1,
        KIND_FLAGS = 2'd2
    } pop_kind_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT2 = 2'd1,
        RTI2 = 2'd2
    } state_t;

endpackage

// File: rtl/stack_ctrl_if.sv
// Core-side op request and stack data-memory bus of stack_ctrl.
interface stack_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] sp;
    logic [31:0] push_data;
    logic [31:0] pc_ret;
    logic [31:0] flags;
    logic [31:0] mem_rdata;
    logic [31:0] sp_next;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] pop_data;
    logic [1:0]  pop_kind;
    logic        pop_valid;
    logic        stall;
    logic        fault;

    modport slave (
        input  op_valid, op, sp, push_data, pc_ret, flags, mem_rdata,
        output sp_next, mem_addr, mem_we, mem_re, mem_wdata,
               pop_data, pop_kind, pop_valid, stall, fault
    );

    modport master (
        output op_valid, op, sp, push_data, pc_ret, flags, mem_rdata,
        input  sp_next, mem_addr, mem_we, mem_re, mem_wdata,
               pop_data, pop_kind, pop_valid, stall, fault
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack op sequencer: decodes PUSH/POP/CALL/RET/INT/RTI into memory accesses
// and the next SP value; INT/RTI run as two-word sequences with bounds checks.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter logic [31:0] STACK_BASE  = DEF_STACK_BASE,
    parameter logic [31:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    stack_ctrl_if.slave  bus
);

    state_t state, state_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.sp_next   = bus.sp;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_wdata = '0;
        bus.pop_data  = '0;
        bus.pop_kind  = KIND_DATA;
        bus.pop_valid = 1'b0;
        bus.stall     = 1'b0;
        bus.fault     = 1'b0;

        if (rst) begin
            state_nx    = IDLE;
            bus.sp_next = STACK_BASE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            OP_PUSH, OP_CALL: begin
                                if (bus.sp <= STACK_LIMIT) begin
                                    bus.fault = 1'b1;
                                end else begin
                                    bus.mem_we    = 1'b1;
                                    bus.mem_addr  = bus.sp;
                                    bus.mem_wdata = (bus.op == OP_PUSH) ? bus.push_data : bus.pc_ret;
                                    bus.sp_next   = bus.sp - 32'd1;
                                end
                            end
                            OP_INT: begin
                                // Both words are checked up front so the pair is refused atomically.
                                if (bus.sp < STACK_LIMIT + 32'd2) begin
                                    bus.fault = 1'b1;
                                end else begin
                                    bus.mem_we    = 1'b1;
                                    bus.mem_addr  = bus.sp;
                                    bus.mem_wdata = bus.pc_ret;
                                    bus.sp_next   = bus.sp - 32'd1;
                                    bus.stall     = 1'b1;
                                    state_nx      = INT2;
                                end
                            end
                            OP_POP, OP_RET: begin
                                if (bus.sp >= STACK_BASE) begin
                                    bus.fault = 1'b1;
                                end else begin
                                    bus.mem_re    = 1'b1;
                                    bus.mem_addr  = bus.sp + 32'd1;
                                    bus.pop_data  = bus.mem_rdata;
                                    bus.pop_kind  = (bus.op == OP_POP) ? KIND_DATA : KIND_PC;
                                    bus.pop_valid = 1'b1;
                                    bus.sp_next   = bus.sp + 32'd1;
                                end
                            end
                            OP_RTI: begin
                                if (bus.sp > STACK_BASE - 32'd2) begin
                                    bus.fault = 1'b1;
                                end else begin
                                    bus.mem_re    = 1'b1;
                                    bus.mem_addr  = bus.sp + 32'd1;
                                    bus.pop_data  = bus.mem_rdata;
                                    bus.pop_kind  = KIND_FLAGS;
                                    bus.pop_valid = 1'b1;
                                    bus.sp_next   = bus.sp + 32'd1;
                                    bus.stall     = 1'b1;
                                    state_nx      = RTI2;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                INT2: begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = bus.sp;
                    bus.mem_wdata = bus.flags;
                    bus.sp_next   = bus.sp - 32'd1;
                    state_nx      = IDLE;
                end
                RTI2: begin
                    bus.mem_re    = 1'b1;
                    bus.mem_addr  = bus.sp + 32'd1;
                    bus.pop_data  = bus.mem_rdata;
                    bus.pop_kind  = KIND_PC;
                    bus.pop_valid = 1'b1;
                    bus.sp_next   = bus.sp + 32'd1;
                    state_nx      = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack memory and SP register.
module tb_stack_ctrl;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stack_ctrl_if bus ();

    stack_ctrl #(.STACK_BASE(32'd900), .STACK_LIMIT(32'd772)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] sp_reg;
    logic [31:0] sp_tab;
    logic        use_reg;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        sp_reg <= bus.sp_next;
    end

    always_comb begin
        bus.mem_rdata = mem[bus.mem_addr[9:0]];
        bus.sp        = use_reg ? sp_reg : sp_tab;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // sp_next, we, re, addr, wdata, pop_valid, pop_data, pop_kind, stall, fault
    task automatic chk_all(input string tag, input logic [31:0] spn, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] wd, input logic pv,
                           input logic [31:0] pd, input logic [1:0] pk, input logic st, input logic ft);
        chk({tag, ".sp_next"},   bus.sp_next, spn);
        chk({tag, ".mem_we"},    32'(bus.mem_we), 32'(we));
        chk({tag, ".mem_re"},    32'(bus.mem_re), 32'(re));
        chk({tag, ".mem_addr"},  bus.mem_addr, addr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
        chk({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(pv));
        chk({tag, ".pop_data"},  bus.pop_data, pd);
        chk({tag, ".pop_kind"},  32'(bus.pop_kind), 32'(pk));
        chk({tag, ".stall"},     32'(bus.stall), 32'(st));
        chk({tag, ".fault"},     32'(bus.fault), 32'(ft));
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] sp;
        logic [31:0] spn;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        pv;
        logic [31:0] pd;
        logic [1:0]  pk;
        logic        st;
        logic        ft;
    } vec_t;

    vec_t tbl [14];

    task automatic drive_op(input logic v, input logic [2:0] op);
        bus.op_valid = v;
        bus.op       = op;
    endtask

    initial begin
        // Memory preloaded with 0xD000_0000 | address so IDLE pops are predictable.
        for (int unsigned a = 0; a < 1024; a++) mem[a] = 32'hD000_0000 | a;
        tbl[0]  = '{1'b0, 3'd0, 850, 850, 0, 0, 0,   0,     0, 0,            0, 0, 0};
        tbl[1]  = '{1'b1, 3'd1, 850, 849, 1, 0, 850, 32'h11, 0, 0,           0, 0, 0};
        tbl[2]  = '{1'b1, 3'd3, 773, 772, 1, 0, 773, 32'h22, 0, 0,           0, 0, 0};
        tbl[3]  = '{1'b1, 3'd1, 772, 772, 0, 0, 0,   0,     0, 0,            0, 0, 1};
        tbl[4]  = '{1'b1, 3'd2, 899, 900, 0, 1, 900, 0,     1, 32'hD0000384, 0, 0, 0};
        tbl[5]  = '{1'b1, 3'd4, 850, 851, 0, 1, 851, 0,     1, 32'hD0000353, 1, 0, 0};
        tbl[6]  = '{1'b1, 3'd2, 900, 900, 0, 0, 0,   0,     0, 0,            0, 0, 1};
        tbl[7]  = '{1'b1, 3'd4, 1000, 1000, 0, 0, 0, 0,     0, 0,            0, 0, 1};
        tbl[8]  = '{1'b1, 3'd5, 774, 773, 1, 0, 774, 32'h22, 0, 0,           0, 1, 0};
        tbl[9]  = '{1'b1, 3'd5, 773, 773, 0, 0, 0,   0,     0, 0,            0, 0, 1};
        tbl[10] = '{1'b1, 3'd6, 898, 899, 0, 1, 899, 0,     1, 32'hD0000383, 2, 1, 0};
        tbl[11] = '{1'b1, 3'd6, 899, 899, 0, 0, 0,   0,     0, 0,            0, 0, 1};
        tbl[12] = '{1'b1, 3'd7, 850, 850, 0, 0, 0,   0,     0, 0,            0, 0, 0};
        tbl[13] = '{1'b1, 3'd0, 850, 850, 0, 0, 0,   0,     0, 0,            0, 0, 0};

        rst = 1'b1; use_reg = 1'b0; sp_tab = 32'd500;
        drive_op(1'b1, 3'd1);
        bus.push_data = 32'h11; bus.pc_ret = 32'h22; bus.flags = 32'h33;
        repeat (2) @(negedge clk);
        chk_all("reset", 900, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive_op(1'b0, 3'd0);

        // Single-cycle table: checked mid-cycle, op dropped before the next edge.
        foreach (tbl[i]) begin
            @(negedge clk);
            sp_tab = tbl[i].sp;
            drive_op(tbl[i].v, tbl[i].op);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].spn, tbl[i].we, tbl[i].re, tbl[i].addr,
                    tbl[i].wd, tbl[i].pv, tbl[i].pd, tbl[i].pk, tbl[i].st, tbl[i].ft);
            drive_op(1'b0, 3'd0);
        end

        // PUSH 0xA5 then POP it back, SP through the register model.
        @(negedge clk);
        sp_reg = 32'd900; use_reg = 1'b1;
        bus.push_data = 32'hA5; drive_op(1'b1, 3'd1);
        #1 chk_all("push", 899, 1, 0, 900, 32'hA5, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("push.mem900", mem[900], 32'hA5);
        drive_op(1'b1, 3'd2);
        #1 chk_all("pop", 900, 0, 1, 900, 0, 1, 32'hA5, 0, 0, 0);
        @(negedge clk);
        drive_op(1'b0, 3'd0);
        chk("pop.sp", bus.sp, 900);

        // INT: two writes, stall only in the first cycle.
        bus.pc_ret = 32'h40; bus.flags = 32'h3; drive_op(1'b1, 3'd5);
        #1 chk_all("int1", 899, 1, 0, 900, 32'h40, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk_all("int2", 898, 1, 0, 899, 32'h3, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive_op(1'b0, 3'd0);
        chk("int.mem900", mem[900], 32'h40);
        chk("int.mem899", mem[899], 32'h3);
        chk("int.sp", bus.sp, 898);

        // RTI: flags then PC.
        drive_op(1'b1, 3'd6);
        #1 chk_all("rti1", 899, 0, 1, 899, 0, 1, 32'h3, 2, 1, 0);
        @(negedge clk);
        chk_all("rti2", 900, 0, 1, 900, 0, 1, 32'h40, 1, 0, 0);
        @(negedge clk);
        drive_op(1'b0, 3'd0);
        chk("rti.sp", bus.sp, 900);

        // Reset in INT2 drops the second word.
        bus.pc_ret = 32'h41; bus.flags = 32'h77; drive_op(1'b1, 3'd5);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all("rstint2", 900, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive_op(1'b0, 3'd0);
        chk("rstint2.mem899", mem[899], 32'h3);
        chk("rstint2.sp", bus.sp, 900);
        #1 chk_all("rstint2.idle", 900, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // CALL then RET back-to-back.
        @(negedge clk);
        bus.pc_ret = 32'h1234; drive_op(1'b1, 3'd3);
        #1 chk_all("call", 899, 1, 0, 900, 32'h1234, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive_op(1'b1, 3'd4);
        #1 chk_all("ret", 900, 0, 1, 900, 0, 1, 32'h1234, 1, 0, 0);
        @(negedge clk);
        drive_op(1'b0, 3'd0);
        chk("ret.sp", bus.sp, 900);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack operation sequencer upstream of the `StackPointer` register in the single-cycle core. It decodes stack operations into data-memory accesses and produces the next SP value, which the register captures every clock. The ops are PUSH, POP, CALL, RET, INT and RTI. Two-word operations (INT, RTI) run as a 2-cycle sequence and stall the core between words. Overflow and underflow are caught, and the faulting operation is suppressed.

## Interface
- `STACK_BASE`, default 900: empty-stack SP value and the reset value of the SP register.
- `STACK_LIMIT`, default 772: lowest legal SP value (128 words deep).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  a stack op is present this cycle.
- `op`  in  3  0 NONE, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI.
- `sp`  in  32  current SP, taken from the StackPointer register output.
- `push_data`  in  32  operand for PUSH.
- `pc_ret`  in  32  return address for CALL and INT.
- `flags`  in  32  flags word for INT.
- `mem_rdata`  in  32  data-memory read data, combinational.
- `sp_next`  out  32  goes to the StackPointer `SP_address` input.
- `mem_addr`  out  32  stack data-memory address.
- `mem_we`  out  1  write enable.
- `mem_re`  out  1  read enable.
- `mem_wdata`  out  32  write data.
- `pop_data`  out  32  popped word: POP result, RET/RTI target PC, or RTI flags.
- `pop_kind`  out  2  0 data, 1 PC, 2 flags.
- `pop_valid`  out  1  `pop_data` is valid this cycle.
- `stall`  out  1  freeze PC and hold op inputs stable.
- `fault`  out  1  one-cycle pulse on overflow or underflow.

## Operation
- Stack grows downward. SP points to the next free slot.
  - Push: write `mem[sp]`, then `sp_next = sp-1`.
  - Pop: read `mem[sp+1]`, then `sp_next = sp+1`.
- When no op is active, `sp_next = sp`, all memory strobes are 0 and `pop_valid` is 0.
- FSM states: IDLE, INT2, RTI2.
- IDLE, single-word ops complete in one cycle with `stall` = 0:
  - PUSH writes `push_data`.
  - CALL writes `pc_ret`.
  - POP pops with `pop_kind` = 0.
  - RET pops with `pop_kind` = 1.
- IDLE + INT:
  - Writes `pc_ret` to `mem[sp]`, `sp_next = sp-1`, `stall` = 1.
  - Moves to INT2.
- INT2:
  - Writes `flags` to `mem[sp]` (sp is now the decremented value), `sp_next = sp-1`, `stall` = 0.
  - Returns to IDLE.
- IDLE + RTI:
  - Pops flags (`pop_kind` = 2), `stall` = 1.
  - Moves to RTI2.
- RTI2:
  - Pops PC (`pop_kind` = 1), `stall` = 0.
  - Returns to IDLE.
- Op inputs are ignored in INT2 and RTI2; the core holds them because `stall` is high.
- Bounds checks use unsigned 32-bit compares and are evaluated in IDLE only:
  - PUSH/CALL: overflow if `sp <= STACK_LIMIT`.
  - INT: overflow if `sp < STACK_LIMIT+2`.
  - POP/RET: underflow if `sp >= STACK_BASE`.
  - RTI: underflow if `sp > STACK_BASE-2`.
- On a fault:
  - `fault` = 1, no memory access, `sp_next = sp`, `pop_valid` = 0, `stall` = 0.
  - State stays IDLE, so a 2-word op is refused atomically.
- Invalid `op` codes (0, 7) behave as NONE.

## Timing
- During reset (`rst` = 1): state goes to IDLE. All outputs are 0 except `sp_next = STACK_BASE`.
- Memory strobes and `sp_next` are combinational from state and inputs. The write and the SP update both take effect on the same rising edge.
- `pop_data` = `mem_rdata` in the same cycle. Read latency is zero.
- Latency: single-word op 1 cycle; INT/RTI exactly 2 cycles, with `stall` high in the first only.
- Reset asserted in INT2 or RTI2: the second word is dropped, state goes to IDLE, and SP returns to STACK_BASE through the register reset.
- Back-to-back ops with no bubble are legal. A new op may be issued the cycle after a completing op.

## Structure
- Shared package `stack_pkg` holds:
  - op encodings;
  - `pop_kind` encodings;
  - FSM state enum;
  - `STACK_BASE` and `STACK_LIMIT` defaults.
- No sub-module. The block is one FSM plus an address/bounds datapath. The StackPointer register stays a separate instance fed by `sp_next`.

## Test plan
- Reset, then PUSH 0xA5 at sp=900 -> `mem[900]` = 0xA5, `sp_next` = 899; then POP at sp=899 -> reads `mem[900]`, `pop_data` = 0xA5, `sp_next` = 900.
- INT at sp=900, `pc_ret` = 0x40, `flags` = 0x3:
  - cycle 1 writes `mem[900]` = 0x40 with `stall` = 1;
  - cycle 2 writes `mem[899]` = 0x3;
  - final SP = 898.
- RTI from sp=898 -> cycle 1 gives flags 0x3 (`pop_kind` = 2), cycle 2 gives PC 0x40 (`pop_kind` = 1); SP ends at 900.
- Boundary:
  - PUSH at sp=772 -> `fault` = 1, no write, SP stays 772.
  - INT at sp=773 -> `fault`, no write.
  - POP at sp=900 -> `fault`.
  - RTI at sp=899 -> `fault`.
- `rst` asserted during INT2 -> second write suppressed, `sp_next` = 900, state IDLE, `stall` = 0.
- CALL then RET back-to-back at sp=900 -> `mem[900]` = `pc_ret`, then the RET pop returns the same value with `pop_kind` = 1; no stall cycles.
